// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I pipeline constants and IF/ID register layout
package rv32i_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_RTYPE  = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_JAL    = 7'h6f;

    typedef struct packed {
        logic                valid;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pc_plus4;
        logic [31:0]         instr;
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with rst > redirect > stall > increment priority
module pc_register
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    // Word alignment is enforced by construction, so pc[1:0] can never be nonzero.
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    assign pc_plus4 = pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC_ALIGNED;
        end else if (redirect_en) begin
            pc <= {redirect_target[XLEN-1:2], 2'b00};
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - RV32I instruction fetch stage and IF/ID pipeline register
module if_id_stage
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    if_id_t          if_id_q;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4)
    );

    assign imem_addr = pc;

    // A flushed slot still captures pc/pc_plus4; only valid and instr define a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q.valid    <= 1'b0;
            if_id_q.pc       <= '0;
            if_id_q.pc_plus4 <= '0;
            if_id_q.instr    <= INSTR_NOP;
        end else if (flush) begin
            if_id_q.valid    <= 1'b0;
            if_id_q.pc       <= pc;
            if_id_q.pc_plus4 <= pc_plus4;
            if_id_q.instr    <= INSTR_NOP;
        end else if (!stall) begin
            if_id_q.valid    <= 1'b1;
            if_id_q.pc       <= pc;
            if_id_q.pc_plus4 <= pc_plus4;
            if_id_q.instr    <= imem_rdata;
        end
    end

    assign id_valid    = if_id_q.valid;
    assign id_pc       = if_id_q.pc;
    assign id_pc_plus4 = if_id_q.pc_plus4;
    assign id_instr    = if_id_q.instr;
    assign id_opcode   = if_id_q.instr[6:0];

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        pc_care;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_p4;
    logic [31:0] m_instr;
    logic        m_care;

    if_id_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_instr        (id_instr),
        .id_opcode       (id_opcode)
    );

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0050_0093;
        else if (a == 32'h4) return 32'h0000_0033;
        else                 return {a[26:2], 7'h37};
    endfunction

    assign imem_rdata = imem(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input logic r_rst, input logic s, input logic f, input logic r,
                        input logic [31:0] t);
        exp_t e;
        rst = r_rst; stall = s; flush = f; redirect_en = r; redirect_target = t;
        if (r_rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0000_0013;
            m_id_pc = 32'h0; m_id_p4 = 32'h0; m_care = 1'b1;
        end else begin
            if (f) begin
                m_valid = 1'b0; m_instr = 32'h0000_0013; m_care = 1'b0;
            end else if (!s) begin
                m_valid = 1'b1; m_instr = imem(m_pc); m_id_pc = m_pc;
                m_id_p4 = m_pc + 32'd4; m_care = 1'b1;
            end
            if (r)       m_pc = {t[31:2], 2'b00};
            else if (!s) m_pc = m_pc + 32'd4;
        end
        e = '{addr: m_pc, valid: m_valid, pc: m_id_pc, pc_plus4: m_id_p4,
              instr: m_instr, pc_care: m_care};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("id_valid", {31'b0, id_valid}, {31'b0, e.valid});
        check("id_instr", id_instr, e.instr);
        check("id_opcode", {25'b0, id_opcode}, {25'b0, e.instr[6:0]});
        if (e.pc_care) begin
            check("id_pc", id_pc, e.pc);
            check("id_pc_plus4", id_pc_plus4, e.pc_plus4);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_target = '0;

        step(1, 0, 0, 0, 0);
        check("reset_valid", {31'b0, id_valid}, 32'h0);
        check("reset_instr", id_instr, 32'h0000_0013);
        check("reset_opcode", {25'b0, id_opcode}, 32'h13);
        check("reset_pc", id_pc, 32'h0);
        check("reset_addr", imem_addr, 32'h0);

        step(0, 0, 0, 0, 0);
        check("first_instr", id_instr, 32'h0050_0093);
        check("first_pc", id_pc, 32'h0);
        check("first_p4", id_pc_plus4, 32'h4);
        check("first_valid", {31'b0, id_valid}, 32'h1);
        step(0, 0, 0, 0, 0);
        check("second_instr", id_instr, 32'h0000_0033);
        check("second_opcode", {25'b0, id_opcode}, 32'h33);
        step(0, 0, 0, 0, 0);
        check("pre_stall_pc", id_pc, 32'h8);

        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0);
            check("stall_id_pc", id_pc, 32'h8);
            check("stall_addr", imem_addr, 32'hC);
        end
        step(0, 0, 0, 0, 0);
        check("post_stall_pc0", id_pc, 32'hC);
        step(0, 0, 0, 0, 0);
        check("post_stall_pc1", id_pc, 32'h10);

        step(0, 0, 1, 1, 32'h100);
        check("redir_bubble", id_instr, 32'h0000_0013);
        check("redir_valid", {31'b0, id_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h100);
        step(0, 0, 0, 0, 0);
        check("redir_target_pc", id_pc, 32'h100);
        check("redir_target_valid", {31'b0, id_valid}, 32'h1);

        step(0, 1, 1, 1, 32'h203);
        check("prio_addr", imem_addr, 32'h200);
        check("prio_valid", {31'b0, id_valid}, 32'h0);
        check("prio_opcode", {25'b0, id_opcode}, 32'h13);
        step(0, 0, 0, 0, 0);
        check("prio_id_pc", id_pc, 32'h200);

        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        check("wrap_pc_hi", id_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        step(0, 0, 0, 0, 0);
        check("wrap_pc_lo", id_pc, 32'h0);

        step(1, 1, 0, 0, 0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", {31'b0, id_valid}, 32'h0);
        check("midrst_instr", id_instr, 32'h0000_0013);
        check("midrst_pc", id_pc, 32'h0);

        for (int i = 0; i < 60; i++) begin
            logic s;
            logic fr;
            s  = ($urandom_range(0, 3) == 0);
            fr = ($urandom_range(0, 5) == 0);
            step(0, s, fr, fr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
